// File: rtl/sum_accum.sv
// Frame accumulator: sums frame_len unsigned samples with saturation and
// presents the total on a valid/ready output, holding input off until taken.
module sum_accum #(
  parameter int IN_W  = 2,
  parameter int ACC_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [CNT_W-1:0] frame_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W:0]   r_cnt;
  logic [CNT_W:0]   r_len;
  logic             r_ovf;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [ACC_W:0]   w_sum_ext;
  logic             w_sat;
  logic [ACC_W-1:0] w_sum_sat;
  logic [CNT_W:0]   w_cnt_inc;
  logic [CNT_W:0]   w_len_eff;
  logic             w_last;

  assign in_ready   = (r_state != S_HOLD);
  assign out_valid  = (r_state == S_HOLD);
  assign busy       = (r_state != S_IDLE);
  assign out_sum    = r_acc;
  assign out_ovf    = r_ovf;

  assign w_in_xfer  = in_valid && (r_state != S_HOLD);
  assign w_out_xfer = out_ready && (r_state == S_HOLD);

  assign w_sum_ext  = {1'b0, r_acc} + (ACC_W+1)'(in_data);
  assign w_sat      = w_sum_ext[ACC_W];
  assign w_sum_sat  = w_sat ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
  assign w_cnt_inc  = r_cnt + (CNT_W+1)'(1);
  // A zero length maps to 2^CNT_W by setting the extra counter bit.
  assign w_len_eff  = {(frame_len == '0), frame_len};
  assign w_last     = (w_cnt_inc == r_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_in_xfer) begin
          w_state_next = (frame_len == CNT_W'(1)) ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_in_xfer && w_last) begin
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_out_xfer) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= '0;
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_xfer) begin
            r_acc <= ACC_W'(in_data);
            r_cnt <= (CNT_W+1)'(1);
            r_len <= w_len_eff;
            r_ovf <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (w_in_xfer) begin
            r_acc <= w_sum_sat;
            r_cnt <= w_cnt_inc;
            if (w_sat) begin
              r_ovf <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          // Sticky overflow lives only as long as its frame is pending.
          if (w_out_xfer) begin
            r_ovf <= 1'b0;
          end
        end
        default: begin
          r_ovf <= 1'b0;
        end
      endcase
    end
  end

endmodule
